// File: rtl/lsu_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lsu_pkg: funct3 codes, FSM state encoding and request legality helper.
// Rev 1.0
// ----------------------------------------------------------------------------
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    CAP  = 2'd2,
    WR   = 2'd3
  } lsu_state_e;

  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    if (!we) ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lsu_lane_align: load lane extraction/extension and sub-word store merge.
// Rev 1.0
// ----------------------------------------------------------------------------
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [31:0] w_sh_b;
  logic [31:0] w_sh_h;
  logic [31:0] w_mask;
  logic [31:0] w_data;

  always_comb begin
    w_sh_b = word_i >> {off_i, 3'b000};
    w_sh_h = word_i >> {off_i[1], 4'b0000};
    case (funct3_i)
      F3_B:    load_o = {{24{w_sh_b[7]}}, w_sh_b[7:0]};
      F3_BU:   load_o = {24'd0, w_sh_b[7:0]};
      F3_H:    load_o = {{16{w_sh_h[15]}}, w_sh_h[15:0]};
      F3_HU:   load_o = {16'd0, w_sh_h[15:0]};
      default: load_o = word_i;
    endcase
  end

  // Memory has no byte enables: splice the new lane(s) into the word just read.
  always_comb begin
    case (funct3_i)
      F3_B: begin
        w_mask = 32'h0000_00FF << {off_i, 3'b000};
        w_data = {24'd0, wdata_i[7:0]} << {off_i, 3'b000};
      end
      F3_H: begin
        w_mask = 32'h0000_FFFF << {off_i[1], 4'b0000};
        w_data = {16'd0, wdata_i[15:0]} << {off_i[1], 4'b0000};
      end
      default: begin
        w_mask = 32'hFFFF_FFFF;
        w_data = wdata_i;
      end
    endcase
    merge_o = (word_i & ~w_mask) | (w_data & w_mask);
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// load_store_unit: RV32I load/store engine with read-modify-write sub-word stores.
// Rev 1.0
// ----------------------------------------------------------------------------
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_BYTES = 256
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req,
  output logic        o_ready,
  input  logic        i_we,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_done,
  output logic        o_fault,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wd,
  output logic        o_mem_wen,
  output logic        o_mem_ren,
  input  logic [31:0] i_mem_rd
);

  localparam int AW = $clog2(MEM_BYTES);

  lsu_state_e  state_q;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] word_q;
  logic [31:0] rdata_q;
  logic        done_q;
  logic        fault_q;

  logic        w_misalign;
  logic        w_range;
  logic        w_fault;
  logic [31:0] w_load;
  logic [31:0] w_merge;

  assign w_misalign = ((i_funct3[1:0] == 2'b01) && i_addr[0]) ||
                      ((i_funct3[1:0] == 2'b10) && (i_addr[1:0] != 2'b00));
  assign w_range    = |i_addr[31:AW];
  assign w_fault    = !f3_legal(i_we, i_funct3) || w_misalign || w_range;

  lsu_lane_align u_align (
    .funct3_i (funct3_q),
    .off_i    (addr_q[1:0]),
    .word_i   (i_mem_rd),
    .wdata_i  (wdata_q),
    .load_o   (w_load),
    .merge_o  (w_merge)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      word_q   <= 32'd0;
      rdata_q  <= 32'd0;
      done_q   <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_req) begin
            if (w_fault) begin
              fault_q <= 1'b1;
            end else begin
              we_q     <= i_we;
              funct3_q <= i_funct3;
              addr_q   <= i_addr;
              wdata_q  <= i_wdata;
              state_q  <= (i_we && (i_funct3 == F3_W)) ? WR : RD;
            end
          end
        end
        RD: state_q <= CAP;
        CAP: begin
          if (we_q) begin
            word_q  <= w_merge;
            state_q <= WR;
          end else begin
            rdata_q <= w_load;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        WR: begin
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_ready    = (state_q == IDLE);
  assign o_rdata    = rdata_q;
  assign o_done     = done_q;
  assign o_fault    = fault_q;
  assign o_mem_addr = (state_q != IDLE) ? {addr_q[31:2], 2'b00} : 32'd0;
  assign o_mem_ren  = (state_q == RD) || (state_q == CAP);
  // Gating with reset keeps an aborted store from reaching memory on the reset edge.
  assign o_mem_wen  = (state_q == WR) && !i_rst;
  assign o_mem_wd   = (state_q != WR) ? 32'd0 :
                      (funct3_q == F3_W) ? wdata_q : word_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_load_store_unit: directed vectors against a word-wide synchronous memory.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  f3 = 3'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        ready, done, fault, mem_wen, mem_ren;
  logic [31:0] rdata, mem_addr, mem_wd;
  logic [31:0] mem_rd = 32'd0;
  logic        preload = 1'b1;
  logic [31:0] mem [0:63];

  int checks = 0;
  int errors = 0;
  int wen_cnt = 0;
  int ren_cnt = 0;
  int done_cnt = 0;

  load_store_unit #(.MEM_BYTES(256)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_req      (req),
    .o_ready    (ready),
    .i_we       (we),
    .i_funct3   (f3),
    .i_addr     (addr),
    .i_wdata    (wdata),
    .o_rdata    (rdata),
    .o_done     (done),
    .o_fault    (fault),
    .o_mem_addr (mem_addr),
    .o_mem_wd   (mem_wd),
    .o_mem_wen  (mem_wen),
    .o_mem_ren  (mem_ren),
    .i_mem_rd   (mem_rd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (preload) begin
      for (int k = 0; k < 64; k++) mem[k] <= 32'd0;
      mem[4] <= 32'h8001_7FFF;
      mem[8] <= 32'h1122_3344;
    end else begin
      if (mem_wen) mem[mem_addr[7:2]] <= mem_wd;
      if (mem_ren) mem_rd <= mem[mem_addr[7:2]];
    end
  end

  always @(negedge clk) begin
    if (mem_wen) wen_cnt++;
    if (mem_ren) ren_cnt++;
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Drive one request, accept it on the next edge, return cycles until done/fault.
  task automatic run(input logic w, input logic [2:0] f, input logic [31:0] a,
                     input logic [31:0] d, output int lat);
    req = 1'b1; we = w; f3 = f; addr = a; wdata = d;
    @(posedge clk); #1;
    req = 1'b0;
    lat = 1;
    while (!done && !fault && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic load(input string tag, input logic [2:0] f, input logic [31:0] a,
                      input logic [31:0] exp);
    int lat;
    run(1'b0, f, a, 32'd0, lat);
    check({tag, "_lat"}, lat, 32'd3);
    check({tag, "_data"}, rdata, exp);
  endtask

  task automatic fault_case(input string tag, input logic w, input logic [2:0] f,
                            input logic [31:0] a);
    int lat, w0, r0;
    w0 = wen_cnt; r0 = ren_cnt;
    run(w, f, a, 32'h1234_5678, lat);
    check({tag, "_lat"}, lat, 32'd1);
    check({tag, "_flt"}, {31'd0, fault}, 32'd1);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_rdy"}, {31'd0, ready}, 32'd1);
    @(posedge clk); #1;
    check({tag, "_mem"}, (wen_cnt - w0) + (ren_cnt - r0), 32'd0);
    check({tag, "_pulse"}, {31'd0, fault}, 32'd0);
  endtask

  initial begin
    int lat, w0, r0, d0;
    @(posedge clk); #1;
    preload = 1'b0;
    @(posedge clk); #1;
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_flags", {30'd0, done, fault}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_mem", {30'd0, mem_wen, mem_ren} | mem_addr | mem_wd, 32'd0);
    rst = 1'b0;

    load("lb13",  3'b000, 32'h13, 32'hFFFF_FF80);
    load("lbu13", 3'b100, 32'h13, 32'h0000_0080);
    load("lh10",  3'b001, 32'h10, 32'h0000_7FFF);
    load("lh12",  3'b001, 32'h12, 32'hFFFF_8001);
    load("lhu12", 3'b101, 32'h12, 32'h0000_8001);
    load("lw10",  3'b010, 32'h10, 32'h8001_7FFF);

    w0 = wen_cnt;
    run(1'b1, 3'b000, 32'h21, 32'h0000_00AB, lat);
    check("sb_lat", lat, 32'd4);
    check("sb_wen", wen_cnt - w0, 32'd1);
    check("sb_word", mem[8], 32'h1122_AB44);
    check("sb_rdata_held", rdata, 32'h8001_7FFF);
    w0 = wen_cnt;
    run(1'b1, 3'b001, 32'h22, 32'h0000_BEEF, lat);
    check("sh_lat", lat, 32'd4);
    check("sh_wen", wen_cnt - w0, 32'd1);
    check("sh_word", mem[8], 32'hBEEF_AB44);

    r0 = ren_cnt;
    run(1'b1, 3'b010, 32'h40, 32'hDEAD_BEEF, lat);
    check("sw_lat", lat, 32'd2);
    check("sw_ren", ren_cnt - r0, 32'd0);
    check("sw_ready", {31'd0, ready}, 32'd1);
    check("sw_word", mem[16], 32'hDEAD_BEEF);
    load("lw40_b2b", 3'b010, 32'h40, 32'hDEAD_BEEF);

    @(posedge clk); #1;
    fault_case("f_lw06",  1'b0, 3'b010, 32'h06);
    fault_case("f_sh31",  1'b1, 3'b001, 32'h31);
    fault_case("f_lw100", 1'b0, 3'b010, 32'h100);
    fault_case("f_f3_011", 1'b0, 3'b011, 32'h10);

    // Abort an SB in its WR cycle with reset.
    w0 = wen_cnt; d0 = done_cnt;
    req = 1'b1; we = 1'b1; f3 = 3'b000; addr = 32'h20; wdata = 32'h55;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rstwr_word", mem[8], 32'hBEEF_AB44);
    check("rstwr_wen", wen_cnt - w0, 32'd0);
    check("rstwr_ready", {31'd0, ready}, 32'd1);
    check("rstwr_flags", {30'd0, done, fault}, 32'd0);
    check("rstwr_rdata", rdata, 32'd0);
    check("rstwr_mem", {30'd0, mem_wen, mem_ren} | mem_addr | mem_wd, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("rstwr_nodone", done_cnt - d0, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
